// File: rtl/operand_gen_pkg.sv
// Shared types, LFSR constants and the Galois LFSR step function for the
// operand generator.
package operand_gen_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int                 LFSR_W    = 16;
  localparam logic [LFSR_W-1:0]  LFSR_TAPS = 16'hB400;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    logic [LFSR_W-1:0] taps;
    taps = x[0] ? LFSR_TAPS : {LFSR_W{1'b0}};
    return (x >> 1) ^ taps;
  endfunction

endpackage

// File: rtl/operand_gen_lfsr_galois.sv
// 16-bit Galois LFSR that advances only when enabled; reset loads the seed.
module lfsr_galois
  import operand_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] value_d;
  logic [LFSR_W-1:0] value_q;

  // Next-state: step when enabled, otherwise hold.
  always_comb begin
    value_d = value_q;
    if (en) begin
      value_d = lfsr_next(value_q);
    end else begin
      value_d = value_q;
    end
  end

  // State register, reloaded with the seed on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= seed;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/operand_gen.sv
// Constrained-random operand source: two LFSRs feed rejection-sampled
// candidates into one-deep hold slots, and complete pairs are moved into a
// valid/ready output register for a programmed number of pairs per burst.
module operand_gen
  import operand_gen_pkg::*;
#(
  parameter int                WIDTH   = 8,
  parameter int                MAX_VAL = 10,
  parameter logic [LFSR_W-1:0] SEED_A  = 16'hACE1,
  parameter logic [LFSR_W-1:0] SEED_B  = 16'h1D0F,
  parameter int                COUNT_W = 16
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_ops,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic               valid,
  input  logic               ready
);

  // Candidates are masked to the smallest power-of-two range covering
  // MAX_VAL, which keeps the acceptance rate at or above one half.
  localparam int              MASK_W = $clog2(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MASK  = WIDTH'((64'd1 << MASK_W) - 64'd1);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hold_a_q, hold_a_d;
  logic [WIDTH-1:0]   hold_b_q, hold_b_d;
  logic               full_a_q, full_a_d;
  logic               full_b_q, full_b_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;

  logic [LFSR_W-1:0]  lfsr_a_s;
  logic [LFSR_W-1:0]  lfsr_b_s;
  logic [WIDTH-1:0]   cand_a_s;
  logic [WIDTH-1:0]   cand_b_s;
  logic               acc_a_s;
  logic               acc_b_s;
  logic               in_run_s;
  logic               out_free_s;
  logic               transfer_s;
  logic               free_a_s;
  logic               free_b_s;
  logic               consume_s;
  logic               unused_lfsr_bits_s;

  lfsr_galois u_lfsr_a (
    .clk   (clk),
    .rst   (rst),
    .en    (free_a_s),
    .seed  (SEED_A),
    .value (lfsr_a_s)
  );

  lfsr_galois u_lfsr_b (
    .clk   (clk),
    .rst   (rst),
    .en    (free_b_s),
    .seed  (SEED_B),
    .value (lfsr_b_s)
  );

  // Only the low WIDTH bits of each LFSR form a candidate.
  assign unused_lfsr_bits_s = ^{lfsr_a_s[LFSR_W-1:WIDTH], lfsr_b_s[LFSR_W-1:WIDTH]};

  // Candidate generation, acceptance test and transfer/free conditions.
  always_comb begin
    cand_a_s   = lfsr_a_s[WIDTH-1:0] & MASK;
    cand_b_s   = lfsr_b_s[WIDTH-1:0] & MASK;
    acc_a_s    = (cand_a_s <= MAX_V);
    acc_b_s    = (cand_b_s <= MAX_V);
    in_run_s   = (state_q == RUN);
    consume_s  = valid_q && ready;
    out_free_s = !valid_q || ready;
    transfer_s = in_run_s && full_a_q && full_b_q &&
                 (remaining_q != {COUNT_W{1'b0}}) && out_free_s;
    // A slot refills on the same edge it empties into the output register.
    free_a_s   = in_run_s && (!full_a_q || transfer_s);
    free_b_s   = in_run_s && (!full_b_q || transfer_s);
  end

  // Hold slots: capture accepted candidates, release on transfer.
  always_comb begin
    hold_a_d = hold_a_q;
    full_a_d = full_a_q;
    hold_b_d = hold_b_q;
    full_b_d = full_b_q;
    if (free_a_s && acc_a_s) begin
      hold_a_d = cand_a_s;
      full_a_d = 1'b1;
    end else if (transfer_s) begin
      full_a_d = 1'b0;
    end else begin
      full_a_d = full_a_q;
    end
    if (free_b_s && acc_b_s) begin
      hold_b_d = cand_b_s;
      full_b_d = 1'b1;
    end else if (transfer_s) begin
      full_b_d = 1'b0;
    end else begin
      full_b_d = full_b_q;
    end
  end

  // Output register: load on transfer, drop valid once consumed.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    if (transfer_s) begin
      a_d     = hold_a_q;
      b_d     = hold_b_q;
      valid_d = 1'b1;
    end else if (consume_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Burst FSM and remaining-pair counter.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    if (transfer_s) begin
      remaining_d = remaining_q - COUNT_W'(1);
    end else begin
      remaining_d = remaining_q;
    end
    unique case (state_q)
      IDLE: begin
        if (start && (num_ops != {COUNT_W{1'b0}})) begin
          state_d     = RUN;
          busy_d      = 1'b1;
          remaining_d = num_ops;
        end else if (start) begin
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Remaining is zero here, so no transfer can coincide with the end.
        if ((remaining_q == {COUNT_W{1'b0}}) && consume_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state registers; reset aborts any burst and empties the slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      hold_a_q    <= {WIDTH{1'b0}};
      hold_b_q    <= {WIDTH{1'b0}};
      full_a_q    <= 1'b0;
      full_b_q    <= 1'b0;
      remaining_q <= {COUNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      full_a_q    <= full_a_d;
      full_b_q    <= full_b_d;
      remaining_q <= remaining_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign a     = a_q;
  assign b     = b_q;

endmodule

// File: doc/operand_gen.md
Name: operand_gen

Overview:
Constrained-random operand source that sits directly upstream of the adder. It feeds the adder's `a`/`b` inputs in hardware, which lets the same stimulus run on-board without a simulator. Each operand comes from its own 16-bit Galois LFSR, and values above a bound are discarded by rejection sampling. Operand pairs are delivered over a valid/ready handshake, in bursts of a programmed length.

Parameters:
- WIDTH, 8: operand width; matches the adder's `a`/`b`.
- MAX_VAL, 10: inclusive upper bound of every operand; must be < 2**WIDTH.
- SEED_A, 16'hACE1: reset value of LFSR A; must be nonzero.
- SEED_B, 16'h1D0F: reset value of LFSR B; must be nonzero.
- COUNT_W, 16: width of the burst-length counter.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: single-cycle request to begin a burst.
- num_ops, in, COUNT_W: number of pairs in the burst; sampled with `start`.
- busy, out, 1: high while a burst is in progress.
- done, out, 1: one-cycle pulse when a burst completes.
- a, out, WIDTH: operand A.
- b, out, WIDTH: operand B.
- valid, out, 1: `a`/`b` hold a pair.
- ready, in, 1: consumer accepts the pair.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - `busy`, `done`, `valid` = 0; `a`, `b` = 0.
  - Hold slots are emptied; the remaining counter = 0.
  - LFSRs load SEED_A / SEED_B.
  - Reset mid-burst aborts the burst: no `done` pulse, and the pair in flight is lost.
- LFSR:
  - next = (x >> 1) ^ (x[0] ? 16'hB400 : 0).
  - LFSRs are NOT reseeded on `start`; the sequence continues across bursts.
- Candidate and acceptance:
  - MASK = 2**clog2(MAX_VAL+1) - 1; for MAX_VAL = 10, MASK = 4'hF.
  - cand_X = lfsr_X[WIDTH-1:0] & MASK.
  - A candidate is accepted iff cand_X <= MAX_VAL.
- Hold slots: one per operand (`hold_X`, `full_X`). A slot is free when `!full_X`, or when it transfers this cycle. On each edge in RUN, with slot X free:
  - if cand_X is accepted: `hold_X` <= cand_X and `full_X` <= 1;
  - LFSR X steps regardless of acceptance.
  - A full, non-transferring slot freezes its LFSR.
- Transfer:
  - Condition: both slots full, remaining != 0, and the output register is free (`!valid`, or `valid && ready`).
  - Effect: `a`/`b` <= `hold_A`/`hold_B`, `valid` <= 1, and remaining decrements.
  - Throughput is at most one pair per cycle.
- Output handshake:
  - A pair is consumed on `valid && ready`.
  - `a`/`b` must be stable while `valid && !ready`.
  - `valid` drops after consumption unless a new transfer occurs on the same edge.
- FSM:
  - IDLE: `start && num_ops != 0` moves to RUN, loads remaining = `num_ops`, `busy` <= 1. `start && num_ops == 0` pulses `done` on the next cycle and stays in IDLE.
  - RUN: when remaining == 0 and the last pair is consumed (`valid && ready`, no new transfer), go to IDLE, `busy` <= 0, and pulse `done` for 1 cycle.
  - Slots may hold surplus values at burst end. These are kept and used first in the next burst.
  - `start` is ignored while `busy`.
- Latency: `start` sampled at edge E0 means `busy` is 1 after E0. The earliest `valid` is after E2; with the default seeds it is after E3 (see Test Plan).
- Rejection-sampling acceptance is ≥ 50% per draw, so no starvation timeout is specified.

Decomposition:
- Package `operand_gen_pkg` holds:
  - the state enum `{IDLE, RUN}`;
  - LFSR_TAPS = 16'hB400 and LFSR_W = 16;
  - the function `lfsr_next()`.
- Sub-module `lfsr_galois` (ports: clk, rst, en, seed, value) is instantiated twice.
- Slot, transfer and FSM logic live in the top module.

Test Plan:
- Reset, then `start` with `num_ops` = 1 and `ready` = 1 → after E1 `hold_A` = 1 (cand 0x1), B rejects 0xF. After E2 `hold_B` = 7. After E3 `valid` = 1, `a` = 1, `b` = 7. `done` pulses after E4; `busy` = 0.
- `num_ops` = 100, `ready` random 50% → exactly 100 handshakes; every `a`, `b` in [0:10]; a single `done`; `busy` high throughout.
- Hold `ready` = 0 for 20 cycles mid-burst → `valid` stays 1 and `a`/`b` stay unchanged. After `ready` rises, no pair is lost or duplicated (check against a reference LFSR model).
- `start` with `num_ops` = 0 → `done` pulses 1 cycle later; `busy` stays 0; `valid` is never asserted.
- Assert `rst` after the 5th handshake of a 50-pair burst → all outputs are 0 immediately, with no `done`. A restarted 1-pair burst yields `a` = 1, `b` = 7 again (seeds reloaded).
- `start` pulsed while `busy` with a different `num_ops` → ignored; the original count is still delivered.
